// File: rtl/zinde_mem_dump_pkg.sv
// zinde_mem_dump_pkg: shared FSM state encoding and default port widths for the
// ZindeRV8 memory dump engine and its output stage.
package zinde_mem_dump_pkg;

  localparam int DEF_ADDR_W = 8;
  localparam int DEF_DATA_W = 8;
  localparam int DEF_RD_LAT = 1;

  // SEND is the hold-until-ready phase of a captured byte; CSUM only ever
  // becomes reachable when the checksum option is compiled in.
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_ACQ  = 3'd1,
    ST_WAIT = 3'd2,
    ST_CAPT = 3'd3,
    ST_SEND = 3'd4,
    ST_DONE = 3'd5,
    ST_CSUM = 3'd6
  } dump_state_e;

endpackage

// File: rtl/zinde_dump_out_stage.sv
// zinde_dump_out_stage: valid/ready holding register for the dump byte stream.
// A load wins over a same-cycle handshake so back-to-back bytes never lose valid.
module zinde_dump_out_stage #(
  parameter int DATA_W = 8
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              load_i,
  input  logic [DATA_W-1:0] load_data_i,
  input  logic              ready_i,
  output logic [DATA_W-1:0] data_o,
  output logic              valid_o
);

  logic [DATA_W-1:0] data_q, data_d;
  logic              valid_q, valid_d;

  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    if (load_i) begin
      data_d  = load_data_i;
      valid_d = 1'b1;
    end else if (valid_q && ready_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  assign data_o  = data_q;
  assign valid_o = valid_q;

endmodule

// File: rtl/zinde_mem_dump.sv
// zinde_mem_dump: takes the ZindeRV8 external RAM port after halt, sweeps an address
// window and streams each byte on valid/ready. `ZINDE_DUMP_CHECKSUM_EN appends a sum byte.
module zinde_mem_dump
  import zinde_mem_dump_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int RD_LAT = DEF_RD_LAT
) (
  input  logic              clkn,
  input  logic              rstn,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_adr,
  input  logic [ADDR_W-1:0] end_adr,
  output logic              sel_out,
  output logic              we_out,
  output logic [ADDR_W-1:0] adr_out,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] dump_data,
  output logic              dump_valid,
  input  logic              dump_ready,
  output logic              busy,
  output logic              done
);

  localparam int               REM_W    = ADDR_W + 1;
  localparam int               LAT_W    = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
  localparam logic [LAT_W-1:0] LAT_INIT = LAT_W'(RD_LAT - 1);
  localparam logic [REM_W-1:0] REM_ONE  = REM_W'(1);

  dump_state_e       state_q, state_d;
  logic [ADDR_W-1:0] adr_q, adr_d;
  logic [ADDR_W-1:0] span;
  logic [REM_W-1:0]  rem_q, rem_d;
  logic [LAT_W-1:0]  lat_q, lat_d;
  logic              load;
  logic [DATA_W-1:0] load_data;
  logic              handshake;

`ifdef ZINDE_DUMP_CHECKSUM_EN
  logic [DATA_W-1:0] csum_q, csum_d;
`endif

  // Window length minus one; the modular difference makes end<start wrap through zero.
  assign span      = end_adr - start_adr;
  assign handshake = dump_valid && dump_ready;

  always_comb begin
    state_d   = state_q;
    adr_d     = adr_q;
    rem_d     = rem_q;
    lat_d     = lat_q;
    load      = 1'b0;
    load_data = mem_rdata;
`ifdef ZINDE_DUMP_CHECKSUM_EN
    csum_d    = csum_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_ACQ;
          adr_d   = start_adr;
          rem_d   = REM_W'(span) + REM_ONE;
`ifdef ZINDE_DUMP_CHECKSUM_EN
          csum_d  = '0;
`endif
        end
      end
      ST_ACQ: begin
        state_d = ST_WAIT;
        lat_d   = LAT_INIT;
      end
      ST_WAIT: begin
        if (lat_q == '0) state_d = ST_CAPT;
        else             lat_d   = lat_q - LAT_W'(1);
      end
      ST_CAPT: begin
        load    = 1'b1;
        state_d = ST_SEND;
      end
      ST_SEND: begin
        if (handshake) begin
          rem_d = rem_q - REM_ONE;
`ifdef ZINDE_DUMP_CHECKSUM_EN
          csum_d = csum_q + dump_data;
`endif
          if (rem_q == REM_ONE) begin
`ifdef ZINDE_DUMP_CHECKSUM_EN
            load      = 1'b1;
            load_data = csum_q + dump_data;
            state_d   = ST_CSUM;
`else
            state_d   = ST_DONE;
`endif
          end else begin
            adr_d   = adr_q + ADDR_W'(1);
            lat_d   = LAT_INIT;
            state_d = ST_WAIT;
          end
        end
      end
      ST_CSUM: begin
        if (handshake) state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clkn or negedge rstn) begin
    if (!rstn) begin
      state_q <= ST_IDLE;
      adr_q   <= '0;
      rem_q   <= '0;
      lat_q   <= '0;
    end else begin
      state_q <= state_d;
      adr_q   <= adr_d;
      rem_q   <= rem_d;
      lat_q   <= lat_d;
    end
  end

`ifdef ZINDE_DUMP_CHECKSUM_EN
  always_ff @(posedge clkn or negedge rstn) begin
    if (!rstn) csum_q <= '0;
    else       csum_q <= csum_d;
  end
`endif

  zinde_dump_out_stage #(
    .DATA_W (DATA_W)
  ) u_out_stage (
    .clk_i       (clkn),
    .rst_ni      (rstn),
    .load_i      (load),
    .load_data_i (load_data),
    .ready_i     (dump_ready),
    .data_o      (dump_data),
    .valid_o     (dump_valid)
  );

  // The port is owned for the whole data sweep, stalls included, and released before any checksum byte.
  assign sel_out = (state_q == ST_ACQ)  || (state_q == ST_WAIT) ||
                   (state_q == ST_CAPT) || (state_q == ST_SEND);
  assign busy    = sel_out || (state_q == ST_CSUM);
  assign done    = (state_q == ST_DONE);
  assign we_out  = 1'b0;
  assign adr_out = adr_q;

endmodule

// File: tb/tb_zinde_mem_dump.sv
// tb_zinde_mem_dump: directed and randomized sweeps of zinde_mem_dump against a RAM model;
// expected streams are built straight from the RAM contents and the window arithmetic.
module tb_zinde_mem_dump;

  logic       clkn = 1'b0;
  logic       rstn = 1'b0;
  logic       start = 1'b0;
  logic [7:0] start_adr = '0;
  logic [7:0] end_adr = '0;
  logic       sel_out;
  logic       we_out;
  logic [7:0] adr_out;
  logic [7:0] mem_rdata = '0;
  logic [7:0] dump_data;
  logic       dump_valid;
  logic       dump_ready = 1'b0;
  logic       busy;
  logic       done;

  logic [7:0] ram [256];
  int         checks = 0;
  int         passCount = 0;

  zinde_mem_dump #(
    .ADDR_W (8),
    .DATA_W (8),
    .RD_LAT (1)
  ) dut (
    .clkn       (clkn),
    .rstn       (rstn),
    .start      (start),
    .start_adr  (start_adr),
    .end_adr    (end_adr),
    .sel_out    (sel_out),
    .we_out     (we_out),
    .adr_out    (adr_out),
    .mem_rdata  (mem_rdata),
    .dump_data  (dump_data),
    .dump_valid (dump_valid),
    .dump_ready (dump_ready),
    .busy       (busy),
    .done       (done)
  );

  always #5 clkn = ~clkn;

  // One-cycle read latency RAM behind the CPU external port.
  always @(posedge clkn) mem_rdata <= ram[adr_out];

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) passCount++;
    else $error("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, expv);
  endtask

  // readyMode: 0 = always ready, 1 = toggle every cycle, 2 = random stalls.
  // abortAfter >= 0 pulls rstn low once that many bytes have been accepted.
  task automatic applyStimulus(input string tag, input logic [7:0] sa, input logic [7:0] ea,
                               input int readyMode, input int abortAfter, input bit restartPulse);
    logic [7:0] expQ[$];
    logic [7:0] got[$];
    logic [7:0] span;
    logic [7:0] a;
    logic [7:0] heldData;
    int len, sum, limit, cyc, doneCnt, firstLat, selViol, stabViol, selAtDone;
    bit holdValid, finished;

    span = ea - sa;
    len  = int'(span) + 1;
    sum  = 0;
    for (int i = 0; i < len; i++) begin
      a = sa + 8'(i);
      expQ.push_back(ram[a]);
      sum += int'(ram[a]);
    end
`ifdef ZINDE_DUMP_CHECKSUM_EN
    expQ.push_back(8'(sum));
`endif
    limit     = len * 12 + 40;
    doneCnt   = 0;
    firstLat  = -1;
    selViol   = 0;
    stabViol  = 0;
    selAtDone = -1;
    holdValid = 0;
    heldData  = '0;
    finished  = 0;

    @(negedge clkn);
    start_adr  = sa;
    end_adr    = ea;
    start      = 1'b1;
    dump_ready = 1'b0;
    @(negedge clkn);
    start     = 1'b0;
    start_adr = 8'($urandom);
    end_adr   = 8'($urandom);
    cyc = 0;

    while (!finished && cyc < limit) begin
      if (holdValid && (!dump_valid || dump_data !== heldData)) stabViol++;
      if (dump_valid && firstLat < 0) firstLat = cyc;
      if (got.size() < len && (!sel_out || !busy)) selViol++;
      if (we_out) selViol++;
      if (done) begin
        doneCnt++;
        selAtDone = int'(sel_out);
        finished = 1;
      end
      start = restartPulse && (cyc == 4);
      if (start) begin
        start_adr = 8'h00;
        end_adr   = 8'hFF;
      end
      case (readyMode)
        0:       dump_ready = 1'b1;
        1:       dump_ready = (cyc % 2 == 0);
        default: dump_ready = ($urandom_range(0, 2) != 0);
      endcase
      if (dump_valid && dump_ready) begin
        got.push_back(dump_data);
        holdValid = 0;
      end else if (dump_valid) begin
        holdValid = 1;
        heldData  = dump_data;
      end else begin
        holdValid = 0;
      end
      if (abortAfter >= 0 && got.size() == abortAfter) begin
        @(negedge clkn);
        rstn = 1'b0;
        #1;
        checkOutput({tag, " abort sel_out"}, 32'(sel_out), 32'd0);
        checkOutput({tag, " abort dump_valid"}, 32'(dump_valid), 32'd0);
        checkOutput({tag, " abort busy"}, 32'(busy), 32'd0);
        for (int k = 0; k < 3; k++) begin
          @(negedge clkn);
          if (done) doneCnt++;
        end
        checkOutput({tag, " abort no done"}, 32'(doneCnt), 32'd0);
        rstn       = 1'b1;
        dump_ready = 1'b0;
        return;
      end
      @(negedge clkn);
      cyc++;
    end
    dump_ready = 1'b0;

    checkOutput({tag, " finished in budget"}, 32'(finished), 32'd1);
    checkOutput({tag, " byte count"}, 32'(got.size()), 32'(expQ.size()));
    for (int i = 0; i < expQ.size() && i < got.size(); i++)
      checkOutput($sformatf("%s byte %0d", tag, i), 32'(got[i]), 32'(expQ[i]));
    checkOutput({tag, " first valid latency"}, 32'(firstLat), 32'd3);
    checkOutput({tag, " done pulses"}, 32'(doneCnt), 32'd1);
    checkOutput({tag, " sel_out at done"}, 32'(selAtDone), 32'd0);
    checkOutput({tag, " port held during sweep"}, 32'(selViol), 32'd0);
    checkOutput({tag, " data stable in stall"}, 32'(stabViol), 32'd0);
    @(negedge clkn);
    checkOutput({tag, " sel_out after"}, 32'(sel_out), 32'd0);
    checkOutput({tag, " busy after"}, 32'(busy), 32'd0);
    checkOutput({tag, " done is a pulse"}, 32'(done), 32'd0);
  endtask

  initial begin
    logic [7:0] t1 [8];
    logic [7:0] sa, ea;
    t1 = '{8'h32, 8'h05, 8'h46, 8'h50, 8'h44, 8'h60, 8'h0f, 8'hff};
    for (int i = 0; i < 256; i++) ram[i] = 8'($urandom);
    for (int i = 0; i < 8; i++) ram[8'h10 + i] = t1[i];
    ram[8'hFE] = 8'hA1;
    ram[8'hFF] = 8'hA2;
    ram[8'h00] = 8'hA3;
    ram[8'h01] = 8'hA4;
    ram[8'h50] = 8'h09;

    #12;
    checkOutput("reset sel_out", 32'(sel_out), 32'd0);
    checkOutput("reset we_out", 32'(we_out), 32'd0);
    checkOutput("reset dump_valid", 32'(dump_valid), 32'd0);
    checkOutput("reset busy", 32'(busy), 32'd0);
    checkOutput("reset done", 32'(done), 32'd0);
    checkOutput("reset adr_out", 32'(adr_out), 32'd0);
    checkOutput("reset dump_data", 32'(dump_data), 32'd0);
    @(negedge clkn);
    rstn = 1'b1;
    repeat (2) @(negedge clkn);

    applyStimulus("t1 window", 8'h10, 8'h17, 0, -1, 0);
    applyStimulus("t2 toggle ready", 8'h10, 8'h17, 1, -1, 0);
    applyStimulus("t3 wrap", 8'hFE, 8'h01, 0, -1, 0);
    applyStimulus("t3 single", 8'h50, 8'h50, 2, -1, 0);
    applyStimulus("t4 abort", 8'h10, 8'h17, 0, 3, 0);
    checkOutput("t4 adr_out reset", 32'(adr_out), 32'd0);
    applyStimulus("t4 rerun", 8'h10, 8'h17, 2, -1, 0);
    applyStimulus("t5 restart ignored", 8'h10, 8'h17, 0, -1, 1);

    for (int r = 0; r < 5; r++) begin
      sa = 8'($urandom);
      ea = (r == 0) ? sa - 8'd1 : sa + 8'($urandom_range(0, 40));
      applyStimulus($sformatf("rand%0d", r), sa, ea, 2, -1, 0);
    end

    $display("%0d/%0d checks passed", passCount, checks);
    $finish;
  end

endmodule
